// File: rtl/bin2bcd_conv_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, BCD constants
// and the scratch-register sizing helper.
package bin2bcd_conv_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  // ceil(bits * log10(2)) in integer arithmetic; bits*log10(2) is never an
  // exact integer for bits > 0, so the rounded constant is safe.
  function automatic int scratch_digits(input int bits);
    return (bits * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_conv_bcd_add3.sv
// Per-digit correction for double-dabble: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bin2bcd_conv_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per CE cycle).
// Define BIN2BCD_LEADING_BLANK_EN to replace leading zero digits with BCD_BLANK.
module bin2bcd_conv
  import bin2bcd_conv_pkg::*;
#(
  parameter int BITS_NUM   = 14,
  parameter int DIGITS_NUM = 4
) (
  input  logic                        CLK,
  input  logic                        CLR,
  input  logic                        CE,
  input  logic                        START,
  input  logic [BITS_NUM-1:0]         IN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [BCD_W*DIGITS_NUM-1:0] Q,
  output logic                        OVF
);

  localparam int SCR  = scratch_digits(BITS_NUM);
  localparam int PW   = (SCR > DIGITS_NUM) ? SCR : DIGITS_NUM;
  localparam int CW   = $clog2(BITS_NUM + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS_NUM - 1);

  state_t                    state;
  logic [BITS_NUM-1:0]       bin;
  logic [BCD_W*SCR-1:0]      scr;
  logic [BCD_W*SCR-1:0]      adj;
  logic [BCD_W*SCR-1:0]      scr_next;
  logic [CW-1:0]             cnt;
  logic [BCD_W*PW-1:0]       padded;
  logic [BCD_W*DIGITS_NUM-1:0] q_next;
  logic                      ovf_next;

  genvar gi;
  generate
    for (gi = 0; gi < SCR; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (scr[BCD_W*gi +: BCD_W]),
        .dout (adj[BCD_W*gi +: BCD_W])
      );
    end
  endgenerate

  assign scr_next = {adj[BCD_W*SCR-2:0], bin[BITS_NUM-1]};

  // Result formatting works on the value after the final shift, so Q is
  // registered on the same edge that completes the conversion.
  always_comb begin
    padded = '0;
    padded[BCD_W*SCR-1:0] = scr_next;
    ovf_next = 1'b0;
    for (int i = DIGITS_NUM; i < PW; i++) begin
      ovf_next = ovf_next | (padded[BCD_W*i +: BCD_W] != 4'd0);
    end
    q_next = '0;
    for (int i = 0; i < DIGITS_NUM; i++) begin
      q_next[BCD_W*i +: BCD_W] = ovf_next ? 4'd9 : padded[BCD_W*i +: BCD_W];
    end
`ifdef BIN2BCD_LEADING_BLANK_EN
    begin : blank
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS_NUM - 1; i >= 1; i--) begin
        if (lead && (q_next[BCD_W*i +: BCD_W] == 4'd0)) begin
          q_next[BCD_W*i +: BCD_W] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      bin   <= '0;
      scr   <= '0;
      cnt   <= '0;
      Q     <= '0;
      OVF   <= 1'b0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else if (CE) begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            bin   <= IN;
            scr   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bin <= bin << 1;
          scr <= scr_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            Q     <= q_next;
            OVF   <= ovf_next;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Scoreboard bench for bin2bcd_conv: stimulus pushes expected results computed
// by an arithmetic decimal model, a monitor pops them on every DONE rise.
module tb_bin2bcd_conv;

  localparam int B = 14;
  localparam int D = 4;

  typedef struct {
    logic [4*D-1:0] q;
    bit             ovf;
    int             v;
  } exp_t;

  logic           CLK = 1'b0;
  logic           CLR = 1'b1;
  logic           CE = 1'b1;
  logic           START = 1'b0;
  logic [B-1:0]   IN = '0;
  logic           BUSY;
  logic           DONE;
  logic [4*D-1:0] Q;
  logic           OVF;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_count = 0;
  int   ce_mode = 0;
  int   clk_cnt = 0;

  bin2bcd_conv #(.BITS_NUM(B), .DIGITS_NUM(D)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .CE    (CE),
    .START (START),
    .IN    (IN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  // CE pattern: 0 = always on, 1 = every 10th clock, 2 = random ~75%.
  initial begin
    forever begin
      @(negedge CLK);
      clk_cnt++;
      if (ce_mode == 1)      CE = (clk_cnt % 10 == 0);
      else if (ce_mode == 2) CE = ($urandom_range(0, 3) != 0);
      else                   CE = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t r;
    int   maxv;
    int   t;
    bit   lead;
    maxv = 1;
    for (int i = 0; i < D; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    r.v = v;
    r.q = '0;
    if (v > maxv) begin
      r.ovf = 1'b1;
      for (int i = 0; i < D; i++) r.q[4*i +: 4] = 4'd9;
    end else begin
      r.ovf = 1'b0;
      t = v;
      for (int i = 0; i < D; i++) begin
        r.q[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
`ifdef BIN2BCD_LEADING_BLANK_EN
    lead = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      if (lead && r.q[4*i +: 4] == 4'd0) r.q[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  // Monitor: every DONE rise consumes one expected result.
  initial begin
    bit   done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (DONE && !done_prev) begin
        done_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(Q), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("q(in=%0d)", e.v), 64'(Q), 64'(e.q));
          check($sformatf("ovf(in=%0d)", e.v), 64'(OVF), 64'(e.ovf));
          $display("result in=%0d q=%h ovf=%0d", e.v, Q, OVF);
        end
      end
      done_prev = DONE;
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (BUSY !== 1'b0 && g < 5000) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 5000) check("idle_timeout", 64'(BUSY), 64'd0);
  endtask

  // Issue one START and wait until that conversion finishes.
  task automatic run_conv(input int v, output int lat, output int busy_n, output int done_clk);
    int g;
    int ce_n;
    bit ce_edge;
    lat = -1; busy_n = 0; done_clk = 0; ce_n = 0; g = 0;
    wait_idle();
    @(negedge CLK);
    IN = B'(v);
    START = 1'b1;
    do begin
      @(posedge CLK);
      ce_edge = CE;
      g++;
    end while (!ce_edge && g < 100);
    exp_q.push_back(model(v));
    @(negedge CLK);
    START = 1'b0;
    IN = B'($urandom);
    if (BUSY) busy_n++;
    if (DONE) done_clk++;
    forever begin
      @(posedge CLK);
      ce_edge = CE;
      g++;
      @(negedge CLK);
      if (DONE) done_clk++;
      if (ce_edge) begin
        ce_n++;
        if (BUSY) busy_n++;
        if (DONE && lat < 0) lat = ce_n;
        if (!BUSY) break;
      end
      if (g > 4000) begin
        check("conv_timeout", 64'(BUSY), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    int lat, busy_n, done_clk, snap, v;
    exp_t last;

    #1;
    check("rst_q", 64'(Q), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_ovf", 64'(OVF), 64'd0);
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);

    // Test 1: nominal conversion with timing checks.
    run_conv(1234, lat, busy_n, done_clk);
    check("t1_latency", 64'(lat), 64'(B));
    check("t1_busy_cycles", 64'(busy_n), 64'(B + 1));
    check("t1_done_width", 64'(done_clk), 64'd1);
    check("t1_q_literal", 64'(Q), 64'h1234);

    // Test 2: saturation boundary.
    run_conv(9999, lat, busy_n, done_clk);
    check("t2_9999_ovf", 64'(OVF), 64'd0);
    run_conv(10000, lat, busy_n, done_clk);
    check("t2_10000_q", 64'(Q), 64'h9999);
    check("t2_10000_ovf", 64'(OVF), 64'd1);
    run_conv(16383, lat, busy_n, done_clk);
    check("t2_16383_ovf", 64'(OVF), 64'd1);

    // Test 3: small values and leading digits.
    run_conv(7, lat, busy_n, done_clk);
`ifdef BIN2BCD_LEADING_BLANK_EN
    check("t3_7_q", 64'(Q), 64'hFFF7);
`else
    check("t3_7_q", 64'(Q), 64'h0007);
`endif
    run_conv(0, lat, busy_n, done_clk);

    // Test 4: START while busy is ignored.
    snap = done_count;
    wait_idle();
    @(negedge CLK);
    IN = B'(42);
    START = 1'b1;
    @(posedge CLK);
    exp_q.push_back(model(42));
    last = model(42);
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    IN = B'(99);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_idle();
    repeat (40) @(negedge CLK);
    check("t4_single_done", 64'(done_count - snap), 64'd1);
    check("t4_busy_after", 64'(BUSY), 64'd0);
    check("t4_q_hold", 64'(Q), 64'(last.q));

    // Random values, CE always on and then random CE.
    for (int n = 0; n < 24; n++) begin
      ce_mode = (n < 12) ? 0 : 2;
      v = (n % 6 == 5) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 16383));
      run_conv(v, lat, busy_n, done_clk);
      check($sformatf("rnd_latency(in=%0d)", v), 64'(lat), 64'(B));
      check($sformatf("rnd_busy(in=%0d)", v), 64'(busy_n), 64'(B + 1));
      if (ce_mode == 0) check($sformatf("rnd_done_width(in=%0d)", v), 64'(done_clk), 64'd1);
    end
    ce_mode = 0;

    // Test 5: CE every 10th clock.
    ce_mode = 1;
    run_conv(500, lat, busy_n, done_clk);
    check("t5_latency_ce", 64'(lat), 64'(B));
    check("t5_done_clocks", 64'(done_clk), 64'd10);
    ce_mode = 0;
    repeat (12) @(negedge CLK);

    // Test 6: asynchronous abort mid-conversion.
    wait_idle();
    @(negedge CLK);
    IN = B'(321);
    START = 1'b1;
    @(posedge CLK);
    exp_q.push_back(model(321));
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    #2;
    CLR = 1'b1;
    exp_q.delete();
    #1;
    check("t6_busy_clr", 64'(BUSY), 64'd0);
    check("t6_done_clr", 64'(DONE), 64'd0);
    check("t6_q_clr", 64'(Q), 64'd0);
    check("t6_ovf_clr", 64'(OVF), 64'd0);
    snap = done_count;
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    repeat (30) @(negedge CLK);
    check("t6_no_done", 64'(done_count - snap), 64'd0);
    check("t6_q_after", 64'(Q), 64'd0);
    run_conv(321, lat, busy_n, done_clk);
    check("t6_restart_q", 64'(Q), 64'(model(321).q));
    repeat (5) @(negedge CLK);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
